herald_cmd_frontend: RTL and testbench

- Byte-serial command front end that sits directly upstream of the MAC and CORDIC units inside tt_um_herald.
- Accepts an opcode byte plus operand bytes from the pin-level byte interface and assembles the 16-bit operands.
- Issues one start/clear pulse to the addressed unit and waits for its done.
- Serializes the result back out, MSB first, under an out_valid/out_ack handshake.

---
 rtl/herald_pkg.sv | 41 ++++
 rtl/herald_resp_serializer.sv | 58 +++++
 rtl/herald_cmd_frontend.sv | 187 ++++++++++++++++++
 tb/tb_herald_cmd_frontend.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/herald_pkg.sv
// Shared opcodes, FSM states and opcode decode helpers for the herald
// byte-serial command front end.
package herald_pkg;

   localparam logic [7:0] OP_MAC_ACC       = 8'h01;
   localparam logic [7:0] OP_MAC_CLEAR     = 8'h02;
   localparam logic [7:0] OP_MAC_READ      = 8'h03;
   localparam logic [7:0] OP_CORDIC_SINCOS = 8'h10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPERANDS,
      ST_ISSUE,
      ST_WAIT_MAC,
      ST_WAIT_CORDIC,
      ST_RESPOND
   } state_e;

   function automatic logic op_legal(input logic [7:0] op);
      logic ok;
      case (op)
         OP_MAC_ACC,
         OP_MAC_CLEAR,
         OP_MAC_READ,
         OP_CORDIC_SINCOS: ok = 1'b1;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] op_operands(input logic [7:0] op);
      logic [2:0] n;
      case (op)
         OP_MAC_ACC:       n = 3'd4;
         OP_CORDIC_SINCOS: n = 3'd2;
         default:          n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/herald_resp_serializer.sv
// Loads a W-bit response word and shifts it out one byte at a time,
// MSB first, under an out_valid/out_ack handshake.
module herald_resp_serializer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         out_ack,
   output logic [7:0]   out_data,
   output logic         out_valid,
   output logic         last
);

   localparam int NB = W / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          vld_q, vld_d;
   logic          adv;

   assign adv       = vld_q && out_ack;
   assign out_data  = sh_q[W-1 -: 8];
   assign out_valid = vld_q;
   assign last      = adv && (idx_q == CW'(NB - 1));

   always_comb begin
      sh_d  = sh_q;
      idx_d = idx_q;
      vld_d = vld_q;
      if (load) begin
         sh_d  = data;
         idx_d = '0;
         vld_d = 1'b1;
      end else if (adv) begin
         sh_d  = sh_q << 8;
         idx_d = idx_q + CW'(1);
         if (idx_q == CW'(NB - 1)) begin
            vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         idx_q <= idx_d;
         vld_q <= vld_d;
      end
   end

endmodule

// File: rtl/herald_cmd_frontend.sv
// Byte-serial command front end: decodes opcodes, assembles operands,
// drives the MAC/CORDIC units and streams 4-byte results back out.
module herald_cmd_frontend
   import herald_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ack,
   output logic              busy,
   output logic              err,
   output logic              mac_start,
   output logic              mac_clear,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   input  logic              mac_done,
   input  logic [ACC_W-1:0]  mac_acc,
   output logic              cordic_start,
   output logic [DATA_W-1:0] cordic_angle,
   input  logic              cordic_done,
   input  logic [DATA_W-1:0] cordic_sin,
   input  logic [DATA_W-1:0] cordic_cos
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [7:0]       op_q, op_d;
   logic [ACC_W-1:0] opnd_q, opnd_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;

   logic             take;
   logic             tmo_hit;
   logic             ser_load;
   logic [ACC_W-1:0] ser_data;
   logic             ser_last;

   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_OPERANDS);
   assign take     = in_valid && in_ready;
   assign busy     = (state_q != ST_IDLE);
   assign err      = err_q;

   assign mac_a        = opnd_q[ACC_W-1 -: DATA_W];
   assign mac_b        = opnd_q[DATA_W-1:0];
   assign cordic_angle = opnd_q[DATA_W-1:0];

   assign mac_start    = (state_q == ST_ISSUE) && (op_q == OP_MAC_ACC);
   assign mac_clear    = (state_q == ST_ISSUE) && (op_q == OP_MAC_CLEAR);
   assign cordic_start = (state_q == ST_ISSUE) && (op_q == OP_CORDIC_SINCOS);

   // The ISSUE cycle counts as the first waited cycle, so the abort
   // lands exactly TIMEOUT cycles after the start pulse.
   assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      err_d    = 1'b0;
      ser_load = 1'b0;
      ser_data = mac_acc;

      if (in_valid && !in_ready) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (take) begin
               op_d   = in_data;
               opnd_d = '0;
               cnt_d  = op_operands(in_data);
               if (!op_legal(in_data)) begin
                  err_d = 1'b1;
               end else if (op_operands(in_data) == 3'd0) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_OPERANDS;
               end
            end
         end
         ST_OPERANDS: begin
            if (take) begin
               opnd_d = {opnd_q[ACC_W-9:0], in_data};
               cnt_d  = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            tmo_d = TW'(1);
            case (op_q)
               OP_MAC_ACC: begin
                  state_d = mac_done ? ST_IDLE : ST_WAIT_MAC;
               end
               OP_MAC_READ: begin
                  ser_load = 1'b1;
                  state_d  = ST_RESPOND;
               end
               OP_CORDIC_SINCOS: begin
                  if (cordic_done) begin
                     ser_load = 1'b1;
                     ser_data = {cordic_sin, cordic_cos};
                     state_d  = ST_RESPOND;
                  end else begin
                     state_d = ST_WAIT_CORDIC;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
         ST_WAIT_MAC: begin
            if (mac_done) begin
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_WAIT_CORDIC: begin
            if (cordic_done) begin
               ser_load = 1'b1;
               ser_data = {cordic_sin, cordic_cos};
               state_d  = ST_RESPOND;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_RESPOND: begin
            if (ser_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   herald_resp_serializer #(
      .W(ACC_W)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .data     (ser_data),
      .out_ack  (out_ack),
      .out_data (out_data),
      .out_valid(out_valid),
      .last     (ser_last)
   );

endmodule

// File: tb/tb_herald_cmd_frontend.sv
// Scoreboard bench for herald_cmd_frontend with simple MAC/CORDIC models.
module tb_herald_cmd_frontend;

   localparam int TIMEOUT = 255;
   localparam int EV_CLR  = 0;
   localparam int EV_START = 1;
   localparam int EV_CST  = 2;
   localparam int EV_ERR  = 3;
   localparam int EV_BYTE = 4;

   typedef struct {
      int          kind;
      logic [31:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ack;
   logic        busy;
   logic        err;
   logic        mac_start;
   logic        mac_clear;
   logic [15:0] mac_a;
   logic [15:0] mac_b;
   logic        mac_done;
   logic [31:0] mac_acc;
   logic        cordic_start;
   logic [15:0] cordic_angle;
   logic        cordic_done;
   logic [15:0] cordic_sin;
   logic [15:0] cordic_cos;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   ev_t  sb[$];
   logic mac_hang = 1'b0;
   logic hold_arm = 1'b0;

   herald_cmd_frontend #(
      .DATA_W (16),
      .ACC_W  (32),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ack     (out_ack),
      .busy        (busy),
      .err         (err),
      .mac_start   (mac_start),
      .mac_clear   (mac_clear),
      .mac_a       (mac_a),
      .mac_b       (mac_b),
      .mac_done    (mac_done),
      .mac_acc     (mac_acc),
      .cordic_start(cordic_start),
      .cordic_angle(cordic_angle),
      .cordic_done (cordic_done),
      .cordic_sin  (cordic_sin),
      .cordic_cos  (cordic_cos)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void push(input int k, input logic [31:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      sb.push_back(e);
   endfunction

   task automatic check_ev(input int k, input logic [31:0] v);
      ev_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d val %h expected none",
                  k, v);
      end else begin
         e = sb.pop_front();
         chk("event_kind", k, e.kind);
         chk("event_val", v, e.val);
      end
   endtask

   // Monitor: every observable DUT action must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (mac_clear)    check_ev(EV_CLR, 32'h0);
         if (mac_start)    check_ev(EV_START, {mac_a, mac_b});
         if (cordic_start) check_ev(EV_CST, {16'h0, cordic_angle});
         if (err)          check_ev(EV_ERR, 32'h0);
         if (out_valid && out_ack) check_ev(EV_BYTE, {24'h0, out_data});
      end
   end

   // MAC model: 3-cycle latency, optional hang.
   initial begin
      logic signed [15:0] pa, pb;
      logic signed [31:0] acc;
      int pend;
      pa = 0; pb = 0; acc = 0; pend = 0;
      mac_done = 1'b0;
      mac_acc  = '0;
      forever begin
         @(posedge clk); #1;
         mac_done = 1'b0;
         if (mac_clear) acc = 0;
         if (mac_start && !mac_hang) begin
            pa = mac_a;
            pb = mac_b;
            pend = 3;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               acc = acc + pa * pb;
               mac_done = 1'b1;
            end
         end
         mac_acc = acc;
      end
   end

   // CORDIC model: fixed result after 16 cycles.
   initial begin
      int pend;
      pend = 0;
      cordic_done = 1'b0;
      cordic_sin  = 16'h0000;
      cordic_cos  = 16'h4DBA;
      forever begin
         @(posedge clk); #1;
         cordic_done = 1'b0;
         if (cordic_start) begin
            pend = 16;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) cordic_done = 1'b1;
         end
      end
   end

   // Host: acks every other cycle; once armed, stalls one byte 5 cycles.
   initial begin
      int  h;
      logic used;
      h = 0;
      used = 1'b0;
      out_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (out_ack) begin
            out_ack = 1'b0;
         end else if (out_valid) begin
            if (hold_arm && !used && h < 5) begin
               h++;
            end else begin
               if (hold_arm) used = 1'b1;
               out_ack = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (!in_ready && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_wait: got in_ready 0 expected 1");
      end
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_bytes(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) begin
         push(EV_BYTE, {24'h0, w[i*8 +: 8]});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int t0;
      rst = 1'b1;
      in_data = 8'h00;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flags",
          {busy, err, out_valid, mac_start, mac_clear, cordic_start}, 0);
      chk("rst_ops", {mac_a, mac_b}, 0);
      chk("rst_data", {out_data, cordic_angle}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // clear, 3*4, -2*5, read -> 2
      push(EV_CLR, 0);
      send(8'h02);
      push(EV_START, 32'h0003_0004);
      send(8'h01); send(8'h00); send(8'h03); send(8'h00); send(8'h04);
      push(EV_START, 32'hFFFE_0005);
      send(8'h01); send(8'hFF); send(8'hFE); send(8'h00); send(8'h05);
      push_bytes(32'h0000_0002);
      send(8'h03);
      @(negedge clk);
      chk("read_lat_issue", out_valid, 0);
      @(negedge clk);
      chk("read_lat_resp", out_valid, 1);

      // cordic with a stalled first byte
      push(EV_CST, 32'h0);
      push_bytes(32'h0000_4DBA);
      send(8'h10); send(8'h00); send(8'h00);
      hold_arm = 1'b1;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("cordic_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold_data", out_data, 8'h00);
         chk("hold_valid", out_valid, 1);
      end

      // illegal opcode, then read still works
      push(EV_ERR, 0);
      send(8'h7F);
      @(negedge clk);
      chk("illegal_in_ready", in_ready, 1);
      chk("illegal_busy", busy, 0);
      push_bytes(32'h0000_0002);
      send(8'h03);

      // overrun during WAIT_CORDIC
      push(EV_CST, 32'h0000_1234);
      push(EV_ERR, 0);
      push_bytes(32'h0000_4DBA);
      send(8'h10); send(8'h12); send(8'h34);
      repeat (3) @(posedge clk);
      #1;
      chk("overrun_in_ready", in_ready, 0);
      in_data  = 8'h55;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;

      // MAC never completes -> timeout
      push(EV_START, 32'h0007_0007);
      push(EV_ERR, 0);
      send(8'h01);
      mac_hang = 1'b1;
      send(8'h00); send(8'h07); send(8'h00); send(8'h07);
      n = 0;
      @(negedge clk);
      while (!mac_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_start_seen", mac_start, 1);
      t0 = cyc;
      n = 0;
      @(negedge clk);
      while (!err && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_err_seen", err, 1);
      chk("tmo_cycles", cyc - t0, TIMEOUT);
      chk("tmo_busy", busy, 0);
      mac_hang = 1'b0;

      // reset mid-operand, then 1*1 onto acc=2
      send(8'h01); send(8'h00); send(8'h05);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      push(EV_START, 32'h0001_0001);
      send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h01);
      push_bytes(32'h0000_0003);
      send(8'h03);

      n = 0;
      while (sb.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drained", sb.size(), 0);
      repeat (3) @(negedge clk);
      chk("end_idle", {busy, out_valid}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
